// File: rtl/rp_decim_pkg.sv
// Shared constants for the ADC decimator.
//   DW        : ADC sample width (signed two's complement)
//   CW        : decimation factor width (factor 1..65536)
//   ACC_GUARD : accumulator headroom bits above DW (log2 of max factor)
//   ACC_W     : accumulator width for the default sample width
//   KW        : width of the averaging shift amount
//   DEC_MAX   : largest supported decimation factor
package rp_decim_pkg;
  localparam int DW        = 14;
  localparam int CW        = 17;
  localparam int ACC_GUARD = 16;
  localparam int ACC_W     = DW + ACC_GUARD;
  localparam int KW        = 5;
  localparam int DEC_MAX   = 65536;
endpackage

// File: rtl/rp_decim_log2.sv
// Power-of-two detector for the decimation factor.
//   n_i    : decimation factor (already mapped so it is never 0)
//   pow2_o : n_i is an exact power of two
//   k_o    : index of the highest set bit of n_i (= log2 when pow2_o)
module rp_decim_log2 #(
  parameter int CW = 17,
  parameter int KW = 5
) (
  input  logic [CW-1:0] n_i,
  output logic          pow2_o,
  output logic [KW-1:0] k_o
);
  always_comb begin
    pow2_o = (n_i != '0) && ((n_i & (n_i - CW'(1))) == '0);
    k_o    = '0;
    for (int i = 0; i < CW; i++)
      if (n_i[i]) k_o = KW'(i);
  end
endmodule

// File: rtl/rp_adc_decim.sv
// ADC decimator: splits the sample stream into windows of N samples and emits
// one output per window, either the window average (N a power of two, avg on)
// or the last sample of the window.
//   adc_clk_i    : ADC clock
//   adc_rst_i    : asynchronous active-high reset
//   adc_dat_i    : raw signed ADC sample, one per clock
//   set_dec_i    : decimation factor N (0 means 1)
//   set_avg_en_i : 1 = average, 0 = last sample
//   adc_rst_do_i : synchronous clear of the window state
//   adc_dat_o    : decimated sample, held between strobes
//   adc_dv_o     : one-cycle strobe marking a new adc_dat_o
//   set_dec1_o   : active window factor is 1
module rp_adc_decim
  import rp_decim_pkg::*;
#(
  parameter int DW = rp_decim_pkg::DW,
  parameter int CW = rp_decim_pkg::CW
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic [DW-1:0] adc_dat_i,
  input  logic [CW-1:0] set_dec_i,
  input  logic          set_avg_en_i,
  input  logic          adc_rst_do_i,
  output logic [DW-1:0] adc_dat_o,
  output logic          adc_dv_o,
  output logic          set_dec1_o
);
  localparam int AW = DW + ACC_GUARD;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0]        cnt_q, cnt_d, n_q, n_d;
  logic                 avg_q, avg_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        dat_q, dat_d;
  logic                 dv_q, dv_d;

  logic                 win_start, last, use_avg, pow2;
  logic [KW-1:0]        k;
  logic signed [AW-1:0] samp_ext, sum;

  // Shift amount comes from the latched factor; it is only consulted from the
  // second sample of a window on, when n_q already holds this window's N.
  rp_decim_log2 #(.CW(CW), .KW(KW)) u_log2 (
    .n_i    (n_q),
    .pow2_o (pow2),
    .k_o    (k)
  );

  always_comb begin
    win_start = (cnt_q == '0);
    // At window start the fresh settings are used immediately so that N=1
    // can complete its window on the very same edge.
    n_d       = win_start ? ((set_dec_i == '0) ? ONE : set_dec_i) : n_q;
    avg_d     = win_start ? set_avg_en_i : avg_q;
    samp_ext  = {{(AW-DW){adc_dat_i[DW-1]}}, adc_dat_i};
    sum       = (win_start ? '0 : acc_q) + samp_ext;
    last      = (cnt_q == n_d - ONE);
    // A one-sample window's average is the sample itself.
    use_avg   = avg_d && pow2 && !win_start;

    cnt_d = last ? '0 : cnt_q + ONE;
    acc_d = sum;
    dv_d  = last;
    dat_d = dat_q;
    if (last) dat_d = use_avg ? DW'(sum >>> k) : adc_dat_i;

    // Window clear wins over a completing window.
    if (adc_rst_do_i) begin
      cnt_d = '0;
      acc_d = '0;
      dv_d  = 1'b0;
      dat_d = dat_q;
      n_d   = n_q;
      avg_d = avg_q;
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
      n_q   <= ONE;
      avg_q <= 1'b0;
      dat_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      n_q   <= n_d;
      avg_q <= avg_d;
      dat_q <= dat_d;
      dv_q  <= dv_d;
    end
  end

  assign adc_dat_o  = dat_q;
  assign adc_dv_o   = dv_q;
  assign set_dec1_o = (n_q == ONE);
endmodule

// File: tb/tb_rp_adc_decim.sv
module tb_rp_adc_decim;
  localparam int DW = 14;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] dat = '0;
  logic [CW-1:0] dec = '0;
  logic          avg = 1'b0;
  logic          rdo = 1'b0;
  logic [DW-1:0] dat_o;
  logic          dv_o;
  logic          dec1_o;

  rp_adc_decim #(.DW(DW), .CW(CW)) dut (
    .adc_clk_i    (clk),
    .adc_rst_i    (rst),
    .adc_dat_i    (dat),
    .set_dec_i    (dec),
    .set_avg_en_i (avg),
    .adc_rst_do_i (rdo),
    .adc_dat_o    (dat_o),
    .adc_dv_o     (dv_o),
    .set_dec1_o   (dec1_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the samples of the open window, plus what was latched.
  int q[$];
  int m_n   = 1;
  bit m_avg = 0;
  int m_dat = 0;
  bit m_dv  = 0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int s14(int v);
    int r;
    r = v & 16'h3fff;
    if (r >= 8192) r -= 16384;
    return r;
  endfunction

  task automatic compare(string tag);
    chk({tag, ".dv"},   int'(dv_o), int'(m_dv));
    chk({tag, ".dat"},  int'($signed(dat_o)), m_dat);
    chk({tag, ".dec1"}, int'(dec1_o), (m_n == 1) ? 1 : 0);
  endtask

  // Apply one sample, clock it in, advance the model, compare.
  task automatic step(string tag, int d, int n, bit a, bit r);
    longint s;
    int k;
    dat = d[DW-1:0];
    dec = n[CW-1:0];
    avg = a;
    rdo = r;
    @(posedge clk);
    #1;
    m_dv = 0;
    if (r) q.delete();
    else begin
      if (q.size() == 0) begin
        m_n   = (n == 0) ? 1 : n;
        m_avg = a;
      end
      q.push_back(s14(d));
      if (q.size() == m_n) begin
        s = 0;
        foreach (q[i]) s += q[i];
        k = -1;
        for (int j = 0; j <= 16; j++) if ((1 << j) == m_n) k = j;
        if (m_avg && k >= 0) m_dat = int'(s >>> k);
        else                 m_dat = q[$];
        m_dv = 1;
        q.delete();
      end
    end
    compare(tag);
  endtask

  // Assert the async reset between edges, hold it over one edge, release.
  task automatic async_reset(string tag);
    rst = 1'b1;
    #2;
    q.delete();
    m_n = 1; m_avg = 0; m_dat = 0; m_dv = 0;
    compare({tag, ".async"});
    @(posedge clk);
    #1;
    compare({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    int cur_dec;
    bit cur_avg;
    int decs[8] = '{0, 1, 2, 3, 4, 7, 8, 16};

    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    compare("reset");
    rst = 1'b0;

    // N=1 ramp: output is the input one clock late, strobe every cycle.
    for (int i = 0; i < 20; i++) step("n1", i, 1, 1'b0, 1'b0);
    // N=0 behaves as N=1.
    for (int i = 0; i < 6; i++) step("n0", 100 + i, 0, 1'b1, 1'b0);

    // N=8 average of 1..8 -> 4; full-scale negative stays -8192.
    step("align", 0, 8, 1'b1, 1'b1);
    for (int w = 0; w < 3; w++)
      for (int i = 1; i <= 8; i++) step("n8avg", i, 8, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("n8neg", -8192, 8, 1'b1, 1'b0);

    // N=5 is not a power of two: last sample.
    for (int w = 0; w < 2; w++)
      for (int i = 1; i <= 5; i++) step("n5", 10 * i, 5, 1'b1, 1'b0);

    // Factor change mid-window only takes effect at the next window.
    for (int i = 0; i < 8; i++) step("chg", 200 + i, (i < 2) ? 8 : 2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step("chg2", 300 + 7 * i, 2, 1'b1, 1'b0);

    // Window clear coinciding with the 4th sample suppresses that output.
    step("align4", 0, 4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("rdo4", 1000, 4, 1'b1, 1'b0);
    step("rdo4hit", 1000, 4, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step("rdo4post", 4 * i - 7, 4, 1'b1, 1'b0);

    // Async reset mid-window discards the partial window.
    for (int i = 0; i < 3; i++) step("pre_rst", 55, 4, 1'b1, 1'b0);
    async_reset("midwin");
    for (int i = 0; i < 8; i++) step("post_rst", 11 * i, 4, 1'b1, 1'b0);

    // Randomized settings, data and occasional window clears.
    cur_dec = 4; cur_avg = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) cur_dec = decs[$urandom_range(0, 7)];
      if ($urandom_range(0, 19) == 0) cur_avg = ~cur_avg;
      step("rand", int'($urandom), cur_dec, cur_avg, $urandom_range(0, 39) == 0);
    end

    // Maximum factor with full-scale positive input: no overflow.
    step("align_max", 0, 65536, 1'b1, 1'b1);
    for (int i = 0; i < 65536; i++) step("max", 8191, 65536, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step("max2", 8191, 65536, 1'b1, 1'b0);
    async_reset("max");
    for (int i = 0; i < 8; i++) step("max_post", 8191 - i, 2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
